// File: rtl/arb_pkg.sv
// Shared definitions for the request arbiters: requester count, index and
// timeout-counter widths, and the arbiter state encoding.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int TO_W    = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority select: returns the first set request bit
// found when searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot_s;
  logic [IDX_W-1:0]   off_s;

  // Rotate requests so bit 0 is the current highest-priority requester.
  always_comb begin
    rot_s = req;
    case (ptr)
      2'd0:    rot_s = req;
      2'd1:    rot_s = {req[0],   req[3:1]};
      2'd2:    rot_s = {req[1:0], req[3:2]};
      2'd3:    rot_s = {req[2:0], req[3]};
      default: rot_s = req;
    endcase
  end

  // Priority-encode the rotated vector into an offset from ptr.
  always_comb begin
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
  end

  assign idx = ptr + off_s;
  assign any = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter driving a 2-to-4 grant decoder.
// Optional grant timeout is built when RR_ARBITER4_TIMEOUT_EN is defined.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               s1,
  output logic               s0,
  output logic               En,
  output logic               expired
);

  arb_state_t       state_r, state_nxt_s;
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
  logic [IDX_W-1:0] sel_r, sel_nxt_s;
  logic             en_r, en_nxt_s;
  logic             expired_r, expired_nxt_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             release_s;
  logic             timeout_s;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign release_s = done | ~req[sel_r];

`ifdef RR_ARBITER4_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] cnt_r;

  // Grant-length counter: held at zero in IDLE, so it starts at 0 on GRANT entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ARB_GRANT) begin
      cnt_r <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= {TO_W{1'b0}};
    end
  end

  assign timeout_s = (cnt_r == TO_LAST);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT;
  assign timeout_s        = 1'b0;
`endif

  // Next-state and next-output logic; a normal release wins over a timeout.
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    sel_nxt_s     = sel_r;
    en_nxt_s      = 1'b0;
    expired_nxt_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = ARB_GRANT;
          sel_nxt_s   = pick_idx_s;
          en_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (release_s) begin
          state_nxt_s = ARB_IDLE;
          ptr_nxt_s   = sel_r + 2'd1;
        end else if (timeout_s) begin
          state_nxt_s   = ARB_IDLE;
          ptr_nxt_s     = sel_r + 2'd1;
          expired_nxt_s = 1'b1;
        end else begin
          en_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // State, pointer and registered decoder outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ARB_IDLE;
      ptr_r     <= 2'd0;
      sel_r     <= 2'd0;
      en_r      <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      sel_r     <= sel_nxt_s;
      en_r      <= en_nxt_s;
      expired_r <= expired_nxt_s;
    end
  end

  assign s1      = sel_r[1];
  assign s0      = sel_r[0];
  assign En      = en_r;
  assign expired = expired_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4 (TIMEOUT=4); the timeout test
// follows RR_ARBITER4_TIMEOUT_EN.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       s1, s0, En, expired;

  int n_checks;
  int n_fail;

  rr_arbiter4 #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .s1      (s1),
    .s0      (s0),
    .En      (En),
    .expired (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({En, s1, s0, expired} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: En,s1,s0,expired=%b required 0000", i, {En, s1, s0, expired});
      end
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({En, s1, s0} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_first_grant: En,idx=%b required 100", {En, s1, s0});
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_idx;
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 6; i++) begin
      exp_idx = 2'(i % 4);
      n_checks++;
      if (En !== 1'b1 || {s1, s0} !== exp_idx) begin
        n_fail++;
        $display("FAIL fair_grant %0d: En=%b idx=%0d required En=1 idx=%0d", i, En, {s1, s0}, exp_idx);
      end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (En !== 1'b0) begin
        n_fail++;
        $display("FAIL fair_gap %0d: En=%b required 0", i, En);
      end
      tick();
    end
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    n_checks++;
    if ({En, s1, s0} !== 3'b110) begin
      n_fail++;
      $display("FAIL wrap_grant2: En,idx=%b required 110", {En, s1, s0});
    end
    req  = 4'b0101;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_checks++;
    if ({En, s1, s0} !== 3'b100) begin
      n_fail++;
      $display("FAIL wrap_to_0: En,idx=%b required 100", {En, s1, s0});
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_checks++;
    if ({En, s1, s0} !== 3'b110) begin
      n_fail++;
      $display("FAIL skip_to_2: En,idx=%b required 110", {En, s1, s0});
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    n_checks++;
    if (En !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_release: En=%b required 0", En);
    end
    req = 4'b1111;
    tick();
    n_checks++;
    if ({En, s1, s0} !== 3'b110) begin
      n_fail++;
      $display("FAIL withdraw_ptr: En,idx=%b required 110", {En, s1, s0});
    end
    // Holder 2 withdraws and strobes done together: pointer must advance once.
    req  = 4'b1011;
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b1111;
    n_checks++;
    if (En !== 1'b0) begin
      n_fail++;
      $display("FAIL both_release: En=%b required 0", En);
    end
    tick();
    n_checks++;
    if ({En, s1, s0} !== 3'b111) begin
      n_fail++;
      $display("FAIL both_single_adv: En,idx=%b required 111", {En, s1, s0});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0011;
    tick();
`ifdef RR_ARBITER4_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({En, s1, s0, expired} !== 4'b1000) begin
        n_fail++;
        $display("FAIL to_hold %0d: En,idx,expired=%b required 1000", i, {En, s1, s0, expired});
      end
      if (i < 3) tick();
    end
    tick();
    n_checks++;
    if (En !== 1'b0 || expired !== 1'b1) begin
      n_fail++;
      $display("FAIL to_expire: En=%b expired=%b required En=0 expired=1", En, expired);
    end
    tick();
    n_checks++;
    if ({En, s1, s0, expired} !== 4'b1010) begin
      n_fail++;
      $display("FAIL to_next_grant: En,idx,expired=%b required 1010", {En, s1, s0, expired});
    end
`else
    for (int i = 0; i < 100; i++) begin
      n_checks++;
      if ({En, s1, s0, expired} !== 4'b1000) begin
        n_fail++;
        $display("FAIL no_to_hold %0d: En,idx,expired=%b required 1000", i, {En, s1, s0, expired});
      end
      tick();
    end
`endif
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    tick();
    tick();
    n_checks++;
    if ({En, s1, s0} !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_grant3: En,idx=%b required 111", {En, s1, s0});
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({En, s1, s0, expired} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset: En,idx,expired=%b required 0000", {En, s1, s0, expired});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({En, s1, s0} !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_regrant: En,idx=%b required 111", {En, s1, s0});
    end
  endtask

  task automatic test_idle_done();
    do_reset();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b0010;
    tick();
    n_checks++;
    if ({En, s1, s0} !== 3'b101) begin
      n_fail++;
      $display("FAIL idle_done_ignored: En,idx=%b required 101", {En, s1, s0});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    done     = 1'b0;
    test_reset();
    test_fairness();
    test_ptr_wrap();
    test_withdraw();
    test_timeout();
    test_reset_mid_grant();
    test_idle_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that produces the select code and enable consumed by the downstream 2-to-4 decoder. The decoder turns this code into one-hot grant lines. The arbiter picks one active requester and holds the grant until that requester releases it. It then rotates priority so every requester is served fairly. It sits between the shared-resource requesters and the grant decoder.

## Interface
- `TIMEOUT`, default 16: maximum grant length in cycles; used only when `RR_ARBITER4_TIMEOUT_EN` is defined; legal range 2..255.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req` input [3:0]: request lines; bit i is requester i; level-sensitive.
- `done` input 1: one-cycle release strobe from the current grant holder.
- `s1` output 1: grant index MSB; drives the decoder `s1`.
- `s0` output 1: grant index LSB; drives the decoder `s0`.
- `En` output 1: grant valid; drives the decoder `En`.
- `expired` output 1: one-cycle pulse on forced release; constant 0 when the timeout feature is out.

## Operation
- State machine with two states: IDLE and GRANT.
- Rotating pointer `ptr[1:0]` holds the highest-priority index.
- **IDLE**
  - `En`=0.
  - If `req`≠0, select the first set bit searching `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (all mod 4).
  - Register the winner into {`s1`,`s0`} and go to GRANT.
  - If `req`=0, stay in IDLE; {`s1`,`s0`} keep their last value.
- **GRANT**
  - `En`=1 and {`s1`,`s0`} are stable.
  - Release when `done`=1, or when `req[sel]`=0 (requester withdrew).
  - On release: go to IDLE, set `ptr` ← `sel`+1 (wraps 3→0), and set `En` to 0 on the next edge.
- Every release is followed by at least one cycle with `En`=0 (break-before-make). The decoder therefore never shows two grants on adjacent cycles without a gap.
- Requests from non-holders during GRANT are ignored; they are re-evaluated in IDLE.
- `done` while in IDLE is ignored.
- Pointer arithmetic is 2-bit modulo; there is no other arithmetic outside the timeout counter.

## Timing
- Reset values (when `rst_n`=0 at an edge): state IDLE, `ptr`=0, `s1`=0, `s0`=0, `En`=0, `expired`=0, timeout counter 0.
- Reset during GRANT: `En` falls at that edge; the grant is discarded and `ptr` returns to 0.
- Grant latency: `req` sampled high in IDLE at edge N gives `En`=1 and a valid index after edge N; requester-visible latency is 1 cycle.
- Release latency: `done` sampled at edge M gives `En`=0 after edge M.
  - The earliest next grant is after edge M+1.
  - Minimum turnaround is therefore 2 cycles per grant.
- All requests active continuously with `done` pulsed each grant: grants go 0,1,2,3,0,… with one idle cycle between them.
- Simultaneous `done` and `req[sel]` deassert: a single release, `ptr` advances once.

## Configuration
- `RR_ARBITER4_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches `TIMEOUT`-1 with no release in that cycle, the grant is force-released: next state IDLE, `ptr` ← `sel`+1, `expired`=1 for exactly one cycle, aligned with `En` falling.
  - If `done` coincides with the timeout cycle, it is a normal release and `expired` stays 0.
- Not defined:
  - No counter is built and `TIMEOUT` is unused.
  - Grants are unbounded.
  - `expired` is tied to 0.

## Structure
- Shared package `arb_pkg` holds:
  - `NUM_REQ`=4, `IDX_W`=2.
  - State enum `arb_state_t` {`ARB_IDLE`, `ARB_GRANT`}.
  - `TO_W`=8.
- Sub-module `rr_pick`: combinational rotating priority select. Inputs `req[3:0]` and `ptr[1:0]`; outputs `idx[1:0]` and `any`. It is reused by other arbiters in the design.
- The top level contains the FSM, the `ptr` register, the output registers and the optional timeout counter.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `req`=4'b1111 → `En`=0, {`s1`,`s0`}=00, `expired`=0 throughout; first grant goes to index 0 one cycle after release of reset.
- Fairness: `req`=4'b1111 constant, `done` pulsed 2 cycles after each grant → index sequence 0,1,2,3,0,1; `En` low one cycle between grants.
- Pointer wrap/skip: grant index 2 released with `req`=4'b0101 → next grant index 0; next `ptr`=1, so with `req`=4'b0101 the following grant is index 2.
- Withdrawal: holder 1 drops `req[1]` without `done` → `En`=0 after that edge and `ptr`=2; a simultaneous `done` produces a single release.
- Timeout (macro on, `TIMEOUT`=4): `req`=4'b0011, no `done` → grant 0 lasts 4 cycles, then `expired`=1 for one cycle and `En`=0, then grant 1; with the macro off, grant 0 holds for 100 cycles.
- Reset mid-grant: `rst_n`=0 during grant 3 → `En`=0 at that edge; after release of reset with `req`=4'b1000, grant index 3 arrives after one cycle.
